fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_types_pkg.sv | 35 +++
 rtl/if_id_latch.sv | 43 ++++
 rtl/fetch_stage.sv | 88 ++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction word, opcode encoding, I-type layout and
// the fetch-stage state encoding.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        LW    = 6'h23,
        SW    = 6'h2B,
        HALT  = 6'h3F
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } i_t;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register: flush beats hold, hold beats load, and an
// enabled cycle without a load becomes a bubble.
import cpu_types_pkg::*;

module if_id_latch (
    input  logic  CLK,
    input  logic  RST,
    input  logic  flush,
    input  logic  enable,
    input  logic  load,
    input  word_t instr_in,
    input  word_t npc_in,
    output word_t instr,
    output word_t npc,
    output logic  valid
);

    // Latch update with flush > hold > load > bubble priority.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instr <= '0;
            npc   <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= '0;
            npc   <= '0;
            valid <= 1'b0;
        end else if (!enable) begin
            instr <= instr;
            npc   <= npc;
            valid <= valid;
        end else if (load) begin
            instr <= instr_in;
            npc   <= npc_in;
            valid <= 1'b1;
        end else begin
            instr <= '0;
            npc   <= '0;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC and the run/halt FSM, drives the
// icache request and feeds the IF/ID latch.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   RUN    | fetching; iREN high, PC advances on accepted hits
//   HALTED | HALT was fetched; iREN low, PC parked on the HALT word
//          | until a redirect (wrong-path HALT) restarts fetching
import cpu_types_pkg::*;

module fetch_stage #(
    parameter word_t PC0 = 32'h00000000
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  pc_enable,
    input  logic  enable_ID,
    input  logic  flush_ID,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  ihit,
    input  word_t iload,
    output logic  iREN,
    output word_t iaddr,
    output word_t instr_ID,
    output word_t npc_ID,
    output logic  valid_ID
);

    fetch_state_t state, state_next;
    word_t        pc, pc_next, pc_plus4;
    logic         fetch_ok;
    logic         is_halt;

    // A hit only counts when running and neither a redirect nor a stall
    // would throw the word away.
    assign fetch_ok = (state == RUN) && ihit && !redirect && !pc_enable;
    assign is_halt  = (opcode_t'(iload[31:26]) == HALT);
    assign pc_plus4 = pc + PC_STEP;
    assign iaddr    = pc;
    assign iREN     = (state == RUN);

    // Next PC: redirect > stall hold > sequential advance > hold.
    always_comb begin
        pc_next = pc;
        if (redirect)
            pc_next = redirect_pc;
        else if (pc_enable)
            pc_next = pc;
        else if (fetch_ok && !is_halt)
            pc_next = pc_plus4;
    end

    // Next FSM state: HALT parks the stage, only a redirect releases it.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (fetch_ok && is_halt) state_next = HALTED;
            HALTED:  if (redirect)            state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // PC and FSM registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc    <= PC0;
            state <= RUN;
        end else begin
            pc    <= pc_next;
            state <= state_next;
        end
    end

    if_id_latch u_if_id (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (flush_ID),
        .enable   (enable_ID),
        .load     (fetch_ok),
        .instr_in (iload),
        .npc_in   (pc_plus4),
        .instr    (instr_ID),
        .npc      (npc_ID),
        .valid    (valid_ID)
    );

endmodule
